// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin front end for a single-ported cache/memory system.
// Latches the winning request, issues it once, waits for hit (with timeout) and returns a done pulse.
module mem_req_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_hit
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    err_next        = err_reg;
    wait_cnt_next   = wait_cnt_reg;
    winner          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first
          winner          = (req0 && req1) ? ~last_grant_reg : req1;
          last_grant_next = winner;
          we_next         = winner ? we1 : we0;
          addr_next       = winner ? addr1 : addr0;
          wdata_next      = winner ? wdata1 : wdata0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          rdata_next = '0;
          state_next = RESP;
        end else if (mem_hit) begin
          rdata_next = mem_rdata;
          state_next = RESP;
        end else begin
          wait_cnt_next = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        // A hit in the final wait cycle beats the timeout
        if (mem_hit) begin
          rdata_next = mem_rdata;
          state_next = RESP;
        end else if (wait_cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          rdata_next = '0;
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      RESP: begin
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_we    = (state_reg == ISSUE) && we_reg;
  assign done0     = (state_reg == RESP) && !last_grant_reg;
  assign done1     = (state_reg == RESP) && last_grant_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;
  assign err       = err_reg;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sequences and shares the single-ported Memorysystem (cache plus backing memory) between two requesters, e.g. an instruction-side and a data-side port of the processor.
- Arbitrates round-robin and latches the winning request.
- Drives a single-cycle write strobe, holds the read address across cache misses until hit, and returns read data with a one-cycle done pulse.
- Adds a miss-wait timeout so a stuck memory cannot hang a requester.

Parameters:
- ADDR_W, 6, address width (matches Memorysystem address)
- DATA_W, 8, data width
- MAX_WAIT, 16, max cycles in WAIT before a read is aborted with error (>=2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request, level, held until done0
- we0  input  1  requester 0: 1=write, 0=read
- addr0  input  ADDR_W  requester 0 address
- wdata0  input  DATA_W  requester 0 write data
- done0  output  1  one-cycle completion pulse to requester 0
- req1, we1, addr1, wdata1, done1  same as above for requester 1
- rdata  output  DATA_W  read data, valid while done0 or done1 is high
- err  output  1  high with done pulse when the read timed out
- mem_we  output  1  to Memorysystem writeen
- mem_addr  output  ADDR_W  to Memorysystem address
- mem_wdata  output  DATA_W  to Memorysystem writedata
- mem_rdata  input  DATA_W  from Memorysystem readdata
- mem_hit  input  1  from Memorysystem hit

Behaviour:
- Reset: all outputs 0, state=IDLE, last_grant=1 (so requester 0 wins first tie), wait_cnt=0. Reset mid-transaction aborts it with no done pulse; mem_we drops in the same edge.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE:
  - If any req is high, pick a winner. With one request, that requester wins. With both, the requester not equal to last_grant wins.
  - Latch the winner's we, addr and wdata into internal regs, set last_grant=winner, go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE, one cycle:
  - mem_addr and mem_wdata come from the latched regs.
  - mem_we = latched we; this is the only cycle mem_we can be 1.
  - Write: go to RESP.
  - Read with mem_hit=1: capture mem_rdata into the rdata reg, go to RESP.
  - Read with mem_hit=0: wait_cnt=0, go to WAIT.
- WAIT:
  - mem_addr held, mem_we=0.
  - mem_hit=1: capture mem_rdata, go to RESP.
  - Else if wait_cnt==MAX_WAIT-1: set err flag, rdata=0, go to RESP.
  - Else wait_cnt++.
  - If hit and timeout land in the same cycle, hit wins and err=0.
- RESP, one cycle:
  - done of the granted requester =1; the other done stays 0.
  - rdata and err are valid this cycle; rdata=0 for writes.
  - Next state IDLE. err clears on leaving RESP.
- Latency, req sampled in IDLE at cycle 0:
  - Write or hit read: done at cycle 2.
  - Miss resolved after N WAIT cycles: done at cycle 2+N.
  - Timeout: done at cycle 2+MAX_WAIT.
- Requesters must drop req in the cycle after done. A req still high in IDLE is treated as a new transaction, which is legal for back-to-back use.
- req changes while a transaction is outside IDLE are ignored; the latched regs are not affected.
- mem_addr and mem_wdata hold their last value in IDLE and RESP; they reset to 0.
- done0 and done1 are never high together. Each fires at most once per grant.
- Fairness: with both requesters held continuously, grants alternate 0,1,0,1.

Test Plan:
1. After reset, req0=1, we0=1, addr0=6'h05, wdata0=8'hA5 → mem_we=1 for exactly one cycle with mem_addr=05 and mem_wdata=A5; done0 pulses at cycle 2; done1=0.
2. req1 read addr1=6'h05 with mem_hit=1 in ISSUE and mem_rdata=A5 → done1 at cycle 2, rdata=A5, err=0, mem_we=0 throughout.
3. Read addr=6'h12 with mem_hit=0 for 3 cycles, then 1 with mem_rdata=3C → mem_addr held at 12 throughout; done at cycle 5; rdata=3C.
4. req0 and req1 both held high for 4 transactions (all hit reads) → grant order 0,1,0,1; done pulses never overlap.
5. mem_hit held 0 with MAX_WAIT=16 → done at cycle 18, err=1, rdata=00; the next transaction has err=0.
6. Assert reset during WAIT → next cycle state=IDLE, all outputs 0, no done pulse; a following req0 write completes normally.
